// File: rtl/vga_plot_sink.sv
`default_nettype none
// ============================================================================
//  Module      : vga_plot_sink
//  Description : Receiving end of the pixel-plot bus. Each plot is optionally
//                clipped to the screen, converted to a frame-memory address,
//                queued in a DEPTH-entry FIFO and written through a req/ack
//                port via a one-entry output register. Counts dropped pixels.
//                Optional feature macro: PLOT_SINK_CLIP_EN (enables the
//                off-screen clip check and clip_count).
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_plot_sink #(
    parameter int DEPTH    = 8,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic        clock_50,
    input  logic        resetn,
    input  logic        vga_plot,
    input  logic [7:0]  vga_x,
    input  logic [7:0]  vga_y,
    input  logic [2:0]  vga_color,
    output logic        mem_wr_req,
    output logic [14:0] mem_addr,
    output logic [2:0]  mem_data,
    input  logic        mem_wr_ack,
    output logic        busy,
    output logic [7:0]  ovf_count,
    output logic [7:0]  clip_count
);

    localparam int c_AW = $clog2(DEPTH);

    // FIFO storage: {address, colour}
    logic [17:0]   fifo_mem [0:DEPTH-1];
    logic [c_AW:0] wr_ptr_q, wr_ptr_d;
    logic [c_AW:0] rd_ptr_q, rd_ptr_d;

    logic          out_valid_q, out_valid_d;
    logic [14:0]   out_addr_q,  out_addr_d;
    logic [2:0]    out_data_q,  out_data_d;
    logic [7:0]    ovf_q,       ovf_d;

    logic          w_empty;
    logic          w_full;
    logic          w_xfer;
    logic          w_pop;
    logic          w_onscreen;
    logic          w_push_req;
    logic          w_push;
    logic [14:0]   w_addr;
    logic [17:0]   w_head;

    assign w_empty = (wr_ptr_q == rd_ptr_q);
    assign w_full  = (wr_ptr_q[c_AW] != rd_ptr_q[c_AW]) &&
                     (wr_ptr_q[c_AW-1:0] == rd_ptr_q[c_AW-1:0]);
    assign w_head  = fifo_mem[rd_ptr_q[c_AW-1:0]];

    // Acknowledge only counts while a request is actually presented
    assign w_xfer  = out_valid_q && mem_wr_ack;
    assign w_pop   = !w_empty && (!out_valid_q || w_xfer);

    // y*160 + x as shifts; truncated to 15 bits so out-of-range input wraps
    assign w_addr  = ({7'd0, vga_y} << 7) + ({7'd0, vga_y} << 5) + {7'd0, vga_x};

`ifdef PLOT_SINK_CLIP_EN
    localparam logic [8:0] c_SCREEN_W = 9'(SCREEN_W);
    localparam logic [8:0] c_SCREEN_H = 9'(SCREEN_H);

    logic [7:0] clip_q, clip_d;

    assign w_onscreen = ({1'b0, vga_x} < c_SCREEN_W) && ({1'b0, vga_y} < c_SCREEN_H);

    // Saturating count of off-screen plots
    always_comb begin
        clip_d = clip_q;
        if (vga_plot && !w_onscreen && (clip_q != 8'hFF)) begin
            clip_d = clip_q + 8'd1;
        end
    end

    // Clip counter register
    always_ff @(posedge clock_50 or negedge resetn) begin
        if (!resetn) begin
            clip_q <= 8'd0;
        end else begin
            clip_q <= clip_d;
        end
    end

    assign clip_count = clip_q;
`else
    assign w_onscreen = 1'b1;
    assign clip_count = 8'd0;
`endif

    assign w_push_req = vga_plot && w_onscreen;
    // A full FIFO can still accept when its head leaves in the same cycle
    assign w_push     = w_push_req && (!w_full || w_pop);

    // FIFO data array; contents need no reset since pointers gate validity
    always_ff @(posedge clock_50) begin
        if (w_push) begin
            fifo_mem[wr_ptr_q[c_AW-1:0]] <= {w_addr, vga_color};
        end
    end

    // Next-state for pointers, output register and overflow counter
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        ovf_d       = ovf_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d    = rd_ptr_q + 1'b1;
            out_valid_d = 1'b1;
            out_addr_d  = w_head[17:3];
            out_data_d  = w_head[2:0];
        end else if (w_xfer) begin
            out_valid_d = 1'b0;
        end
        if (w_push_req && !w_push && (ovf_q != 8'hFF)) begin
            ovf_d = ovf_q + 8'd1;
        end
    end

    // State registers; reset drops any queued or pending pixel at once
    always_ff @(posedge clock_50 or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= 15'd0;
            out_data_q  <= 3'd0;
            ovf_q       <= 8'd0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            ovf_q       <= ovf_d;
        end
    end

    assign mem_wr_req = out_valid_q;
    assign mem_addr   = out_addr_q;
    assign mem_data   = out_data_q;
    assign busy       = !w_empty || out_valid_q;
    assign ovf_count  = ovf_q;

endmodule
`default_nettype wire

// File: doc/vga_plot_sink.md
# vga_plot_sink

Receiving end of the pixel-plot bus driven by the display controllers (`vga_plot`, `vga_x`, `vga_y`, `vga_color`). It accepts at most one plot per clock. Each accepted plot is clipped to the 160x120 screen, queued in a small FIFO, and written into the 3-bit-per-pixel frame memory through a req/ack write port, because the frame memory is shared with scan-out. The block counts dropped pixels so the display controllers can be debugged from the board LEDs.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, 2..64.
- `SCREEN_W`, 160: visible width in pixels.
- `SCREEN_H`, 120: visible height in pixels.

Ports:
- `clock_50`  in  1  system clock; all logic on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `vga_plot`  in  1  plot strobe; one pixel per cycle while high.
- `vga_x`  in  8  pixel column.
- `vga_y`  in  8  pixel row.
- `vga_color`  in  3  pixel colour {R,G,B}.
- `mem_wr_req`  out  1  frame-memory write request.
- `mem_addr`  out  15  pixel address, y*SCREEN_W + x.
- `mem_data`  out  3  pixel colour.
- `mem_wr_ack`  in  1  memory accepts the write this cycle.
- `busy`  out  1  high while the FIFO or the output stage holds a pixel.
- `ovf_count`  out  8  saturating count of pixels dropped because the block was full.
- `clip_count`  out  8  saturating count of off-screen pixels dropped.

## Operation
- Input is sampled on every edge where `vga_plot`=1. There is no backpressure: a pixel is either accepted or dropped and counted.
- Clip check, at input, before the FIFO (only with the macro):
  - off-screen means `vga_x` ≥ SCREEN_W or `vga_y` ≥ SCREEN_H;
  - an off-screen pixel is discarded, `clip_count`++, and takes no FIFO slot.
- Address computation, at input:
  - formula: `(y<<7)+(y<<5)+x`, computed at 15 bits, stored in the FIFO with the colour;
  - maximum in-range value: 19199.
- Storage:
  - the FIFO has DEPTH entries, plus a one-entry output register that drives `mem_addr`/`mem_data`;
  - total capacity is DEPTH+1.
- Push is accepted when either:
  - the FIFO is not full; or
  - the FIFO is full and a pop occurs in the same cycle.
  Otherwise the pixel is dropped and `ovf_count`++.
- Output register:
  - it is "valid" when it holds a pixel, and `mem_wr_req` = valid;
  - it loads the FIFO head when empty, or when a transfer (`mem_wr_req`&&`mem_wr_ack`) happens this cycle;
  - when the FIFO is empty and the register is empty, an incoming accepted pixel still goes through the FIFO (no bypass).
- Handshake:
  - while `mem_wr_req`=1, `mem_addr`/`mem_data` are held stable until the transfer;
  - `mem_wr_ack` is ignored while `mem_wr_req`=0.
- Ordering is strict FIFO; no coalescing of writes to the same address.
- Counters saturate at 255 and are cleared only by reset.
- `busy` = FIFO non-empty OR output register valid.

## Timing
- Reset values: `mem_wr_req`=0, `mem_addr`=0, `mem_data`=0, `busy`=0, `ovf_count`=0, `clip_count`=0; FIFO pointers zeroed.
- Reset is asynchronous: asserting `resetn` mid-operation discards all queued pixels immediately and does not complete a pending transfer.
- Latency into an idle block:
  - plot sampled at edge k is written to the FIFO at edge k;
  - the output register loads at edge k+1, and `mem_wr_req` is high after edge k+1.
- Throughput: with `mem_wr_ack` held high, one transfer per cycle. A continuous plot stream is sustained with zero drops.
- Counter updates are visible one edge after the sampled plot.

## Configuration
- `PLOT_SINK_CLIP_EN` defined:
  - the clip check is active and `clip_count` counts as described.
- `PLOT_SINK_CLIP_EN` undefined:
  - no clip check; every plot goes to the FIFO;
  - the address is computed the same way and truncated to 15 bits, so it wraps modulo 32768;
  - `clip_count` is tied to 0.

## Test plan
- Idle block, single plot x=5 y=3 colour 3'b101, `mem_wr_ack`=0 for 4 cycles then 1 → `mem_wr_req` rises 2 edges after the plot, addr 485 and data 5 held stable until the ack, then `mem_wr_req`=0 and `busy`=0.
- `mem_wr_ack`=0, 10 consecutive plots (x=0..9, y=0), DEPTH=8 → 9 accepted, `ovf_count`=1; then ack=1 → 9 transfers, addresses 0..8 in order.
- Clip (macro defined): plots (160,0), (0,120), (159,119) → `clip_count`=2, exactly one write at addr 19199. With the macro undefined → three writes, at addresses 160, 19200 and 19199.
- `mem_wr_ack` held 1, plot every cycle for 200 cycles → 200 transfers, one per cycle in order, `ovf_count`=0.
- Saturation: ack=0, 300 plots → `ovf_count`=255 and holds at 255.
- Reset mid-burst: 5 pixels queued, `resetn` pulsed low → all outputs at reset values immediately, no further transfers after release.
